// File: rtl/fp_floor.sv
// fp_floor: binary32 floor (round toward -inf), one-cycle registered result.
module fp_floor (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] src,
    output logic        out_valid,
    output logic [31:0] dest
);

    localparam int unsigned W     = 32;
    localparam int unsigned MAG_W = 31;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX  = 8'd255;
    localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
    localparam logic [EXP_W-1:0] EXP_INT  = 8'd150;
    localparam logic [W-1:0]     NEG_ONE  = 32'hBF80_0000;
    localparam logic [W-1:0]     QNAN_BIT = 32'h0040_0000;

    logic                sign;
    logic [EXP_W-1:0]    exp_f;
    logic [MAN_W-1:0]    man_f;
    logic [MAG_W-1:0]    mag;
    logic [EXP_W-1:0]    frac_w;
    logic [MAG_W-1:0]    frac_mask;
    logic [MAG_W-1:0]    trunc_mag;
    logic [MAG_W-1:0]    ulp_inc;
    logic                frac_nz;
    logic [W-1:0]        floor_c;

    assign sign  = src[31];
    assign exp_f = src[30:23];
    assign man_f = src[22:0];
    assign mag   = src[30:0];

    // Fraction-bit mask for exponents 127..149; width is 150-E (1..23 there).
    always_comb begin
        frac_w    = EXP_INT - exp_f;
        frac_mask = MAG_W'((MAG_W'(1) << frac_w) - MAG_W'(1));
        ulp_inc   = MAG_W'(MAG_W'(1) << frac_w);
        trunc_mag = mag & ~frac_mask;
        frac_nz   = |(mag & frac_mask);
    end

    // Select the floor result by exponent class.
    always_comb begin
        floor_c = src;
        if (exp_f == EXP_MAX) begin
            // Inf passes through; NaN is quieted keeping sign and payload.
            floor_c = (man_f == '0) ? src : (src | QNAN_BIT);
        end else if (exp_f == '0) begin
            // Zero keeps its sign; subnormals collapse to +0 or -1.
            if (man_f == '0) begin
                floor_c = src;
            end else begin
                floor_c = sign ? NEG_ONE : W'(0);
            end
        end else if (exp_f < EXP_BIAS) begin
            floor_c = sign ? NEG_ONE : W'(0);
        end else if (exp_f >= EXP_INT) begin
            floor_c = src;
        end else if (sign && frac_nz) begin
            // Negative with fraction: step magnitude up one unit; carry may bump exponent.
            floor_c = {sign, MAG_W'(trunc_mag + ulp_inc)};
        end else begin
            floor_c = {sign, trunc_mag};
        end
    end

    // Output register; dest holds when no operand is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dest      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dest <= floor_c;
            end
        end
    end

endmodule

// File: tb/tb_fp_floor.sv
// tb_fp_floor: scoreboard bench for fp_floor against a real-arithmetic floor model.
module tb_fp_floor;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] src;
    logic        out_valid;
    logic [31:0] dest;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_q[$];
    bit          exp_valid   = 1'b0;
    logic [31:0] held        = 32'h0;

    always #5 clk = ~clk;

    fp_floor dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .src       (src),
        .out_valid (out_valid),
        .dest      (dest)
    );

    // Reference: decode to real, take $floor, re-encode the integer.
    function automatic logic [31:0] ref_floor(input logic [31:0] x);
        logic   s;
        int     e_raw;
        int     m_raw;
        real    v;
        real    fl;
        longint k;
        int     p;
        s     = x[31];
        e_raw = int'(x[30:23]);
        m_raw = int'(x[22:0]);
        if (e_raw == 255) return (m_raw == 0) ? x : (x | 32'h0040_0000);
        if (e_raw == 0 && m_raw == 0) return x;
        if (e_raw == 0) v = real'(m_raw) * (2.0 ** (-149));
        else            v = real'(m_raw + 8388608) * (2.0 ** (e_raw - 150));
        if (s) v = -v;
        fl = $floor(v);
        if (fl == v) return x;
        k = longint'((fl < 0.0) ? -fl : fl);
        if (k == 0) return 32'h0;
        p = 0;
        while ((k >> (p + 1)) != 0) p++;
        return {s, 8'(127 + p), 23'((k << (23 - p)) & 64'h7F_FFFF)};
    endfunction

    // Monitor: checks each cycle's output against the oldest expected result.
    always @(negedge clk) begin
        logic [31:0] e;
        e = held;
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty: no expected result queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
            end
        end
        if (out_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL out_valid: got %b want %b at %0t", out_valid, exp_valid, $time);
        end else if (exp_valid) begin
            vectors++;
            if (dest !== e) begin
                miscompares++;
                $display("FAIL dest: got %08h want %08h at %0t", dest, e, $time);
            end
            held = e;
        end else if (dest !== held) begin
            miscompares++;
            $display("FAIL dest_hold: got %08h want %08h at %0t", dest, held, $time);
        end
        exp_valid = in_valid && !reset;
        if (reset) held = 32'h0;
    end

    task automatic apply_exp(input logic [31:0] x, input logic [31:0] want);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        src      = x;
        exp_q.push_back(want);
    endtask

    task automatic apply(input logic [31:0] x);
        apply_exp(x, ref_floor(x));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src      = $urandom;
    endtask

    initial begin
        logic [31:0] r;
        int          waited;
        reset    = 1'b1;
        in_valid = 1'b1;
        src      = 32'h3FC0_0000;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || dest !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b d=%08h want v=0 d=00000000", out_valid, dest);
        end
        reset = 1'b0;
        exp_q.push_back(32'h3F80_0000);

        // Negative fractions back-to-back
        apply_exp(32'hBFC0_0000, 32'hC000_0000);
        apply_exp(32'hC049_0FDB, 32'hC080_0000);
        apply_exp(32'hBF00_0000, 32'hBF80_0000);
        idle();
        // Small and subnormal magnitudes
        apply_exp(32'h3F00_0000, 32'h0000_0000);
        apply_exp(32'h0000_0001, 32'h0000_0000);
        apply_exp(32'h8000_0001, 32'hBF80_0000);
        apply_exp(32'h8000_0000, 32'h8000_0000);
        idle();
        idle();
        // Integral and boundary values
        apply_exp(32'h4B00_0001, 32'h4B00_0001);
        apply_exp(32'hCB7F_FFFF, 32'hCB7F_FFFF);
        apply_exp(32'hC000_0000, 32'hC000_0000);
        apply_exp(32'hBF80_0000, 32'hBF80_0000);
        apply_exp(32'hCAFF_FFFF, 32'hCB00_0000);
        // Specials
        apply_exp(32'h7F80_0000, 32'h7F80_0000);
        apply_exp(32'hFF80_0000, 32'hFF80_0000);
        apply_exp(32'h7FA0_0000, 32'h7FE0_0000);
        apply_exp(32'hFFC0_0001, 32'hFFC0_0001);
        idle();

        // Random sweep over every finite nonzero exponent
        for (int ex = 1; ex <= 254; ex++) begin
            for (int n = 0; n < 100; n++) begin
                r = $urandom;
                apply({r[31], 8'(ex), 23'($urandom)});
                if ($urandom_range(0, 15) == 0) idle();
            end
        end
        idle();

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d results pending want 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_floor.md
Name: fp_floor

Overview:
- Computes floor(x), rounding toward negative infinity, for one IEEE-754 binary32 operand.
- Result is an integral-valued binary32.
- Used by the FPU as the floor instruction unit. Registered output, latency of one cycle.
- No rounding-mode input and no exception flags.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  src is valid this cycle.
- src  input  32  operand: {sign[31], exp[30:23], man[22:0]}.
- out_valid  output  1  dest holds a result this cycle.
- dest  output  32  floor(src), binary32.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset:
  - When reset=1 at a rising edge: dest<=32'h0 and out_valid<=0.
  - Reset overrides in_valid in that cycle.
  - An operand presented in a reset cycle is discarded.
- Pipeline:
  - Fully combinational datapath followed by one output register stage.
  - If in_valid=1 at edge N, then at edge N+1 dest=floor(src sampled at N) and out_valid=1.
  - If in_valid=0, out_valid<=0 and dest holds its previous value.
  - Accepts one operand every cycle. No backpressure, no stall.
- Definitions: s=src[31], E=src[30:23], M=src[22:0], e=E-127 (signed).
- Case E=255 (Inf or NaN):
  - Inf: dest=src.
  - NaN: dest=src with bit 22 forced to 1 (quieted). Sign and payload are kept.
- Case E=0 (zero or subnormal):
  - M=0: dest=src, so signed zero is preserved.
  - M!=0 and s=0: dest=32'h00000000.
  - M!=0 and s=1: dest=32'hBF800000 (-1.0).
- Case 1<=E<=126 (0 < |x| < 1):
  - s=0: dest=32'h00000000.
  - s=1: dest=32'hBF800000.
- Case E>=150 (e>=23, already integral): dest=src.
- Case 127<=E<=149 (0<=e<=22):
  - Fraction width f=23-e, range 1..23.
  - frac=M[f-1:0]. T = src[30:0] with bits [f-1:0] cleared.
  - If s=0 or frac=0: dest={s,T}.
  - If s=1 and frac!=0: dest={s, T + (1<<f)}, using a 31-bit add over the {exp,man} field.
  - A mantissa carry increments the exponent, e.g. -1.5 gives -2.0.
  - The result cannot overflow to Inf, since e<=22.
- The result is exact. The sign of the result always equals the sign of the input.
- The mask and increment use a barrel shift or thermometer mask generated from e. There is no multi-cycle iteration.

Test Plan:
- Reset: assert reset with in_valid=1, src=32'h3FC00000 -> next cycle out_valid=0 and dest=32'h0. Deassert reset; src=32'h3FC00000 (1.5) -> dest=32'h3F800000 one cycle later with out_valid=1.
- Negative fractions, applied back-to-back:
  - 32'hBFC00000 (-1.5) -> 32'hC0000000.
  - 32'hC0490FDB (-3.14159) -> 32'hC0800000.
  - 32'hBF000000 (-0.5) -> 32'hBF800000.
  - Each result appears one cycle after its input, with out_valid=1 on consecutive cycles.
- Small and subnormal magnitudes:
  - 32'h3F000000 (0.5) -> 32'h00000000.
  - 32'h00000001 -> 32'h00000000.
  - 32'h80000001 -> 32'hBF800000.
  - 32'h80000000 -> 32'h80000000.
- Integral and boundary values:
  - 32'h4B000001 -> unchanged.
  - 32'hCB7FFFFF -> unchanged.
  - 32'hC0000000 (-2.0) -> unchanged.
  - 32'hBF800000 (-1.0) -> unchanged.
  - 32'hCAFFFFFF (-8388607.5) -> 32'hCB000000.
- Specials:
  - 32'h7F800000 -> 32'h7F800000.
  - 32'hFF800000 -> 32'hFF800000.
  - 32'h7FA00000 -> 32'h7FE00000.
- Random sweep: every E in 1..254 with 100 random sign/mantissa pairs each. dest must be bit-exact against a floor() reference model. No mismatches are allowed.
